load_order_queue: RTL and testbench
===================================

// Module: load_order_queue
// PURPOSE
//  Circular load-ordering queue for the out-of-order load/store unit. Records issued loads
//  (sqN, word address, byte mask) indexed by loadSqN. Checks every issued store against
//  younger loads already executed to the same bytes and raises a replay branch on a hit.
//  Retires committed loads from the head and publishes the youngest loadSqN rename may allocate.
// PARAMETERS
//  NUM_PORTS    2   AGU ports presenting loads/stores per cycle
//  NUM_ENTRIES  16  queue depth; power of two, <= 2**(SQN_W-1)
//  SQN_W        6   width of sqN/loadSqN/storeSqN; wrap-around sequence numbers
//  COMMIT_W     2   max entries retired per cycle
// PORTS
//  clk              in   1             clock
//  rst              in   1             async reset, active-high
//  IN_commitSqN     in   SQN_W         oldest uncommitted sqN
//  IN_valid         in   NUM_PORTS     port op valid
//  IN_isLoad        in   NUM_PORTS     1=load, 0=store
//  IN_pc            in   NUM_PORTS*32  op PC
//  IN_addr          in   NUM_PORTS*32  byte address
//  IN_size          in   NUM_PORTS*2   0=byte 1=half 2=word
//  IN_sqN           in   NUM_PORTS*SQN_W   op sqN
//  IN_loadSqN       in   NUM_PORTS*SQN_W   op loadSqN
//  IN_storeSqN      in   NUM_PORTS*SQN_W   op storeSqN
//  IN_branch        in   BranchProv_t  incoming mispredict/flush
//  OUT_branch       out  BranchProv_t  ordering-violation replay request
//  OUT_maxLoadSqN   out  SQN_W         youngest allocatable loadSqN
// BEHAVIOUR
//  - Reset (async): all entry valid=0; head=0; OUT_branch.taken=0; OUT_maxLoadSqN=NUM_ENTRIES-1.
//  - Age: a older than b iff $signed(a-b) < 0, computed in SQN_W bits.
//  - Kill: port op is killed if IN_branch.taken and sqN younger than IN_branch.sqN.
//  - Load insert (not killed): entry[loadSqN mod NUM_ENTRIES] <= {valid=1,sqN,addr[31:2],mask}.
//    mask = size-aligned byte enables from addr[1:0]. Visible to store checks the next cycle.
//  - Store check (not killed): violation if any valid entry, or any same-cycle unkilled load on
//    another port, has equal addr[31:2], overlapping mask, and sqN younger than the store.
//  - Among violating store ports choose the one with the oldest sqN; the next cycle OUT_branch
//    = {taken=1, dstPC=store pc, sqN, loadSqN, storeSqN of that store, flush=0}; otherwise taken=0.
//    Latency: 1 cycle. OUT_branch.taken is a one-cycle pulse per violation.
//  - Mispredict (IN_branch.taken): invalidate entries younger than IN_branch.sqN; if
//    IN_branch.flush, head <= IN_branch.loadSqN. Retire is suppressed this cycle.
//  - Retire (no mispredict): starting at head, retire up to COMMIT_W consecutive entries that are
//    valid and older than IN_commitSqN; stop at the first that fails. Clear valid; head += n.
//  - OUT_maxLoadSqN <= head_next + NUM_ENTRIES - 1, registered (mod 2**SQN_W).
//  - Wrap: head and indices wrap modulo NUM_ENTRIES; sqN compares wrap via signed difference.
//  - Full: upstream never issues loadSqN beyond OUT_maxLoadSqN; the bench asserts this and no
//    overwrite of a valid entry.
//  - Same-cycle retire and insert to the same slot: insert wins (slot was freed this cycle).
// CONFIGURATION
//  LQ_BYTE_MASK_EN defined: overlap requires equal word address AND (maskA & maskB) != 0.
//  Undefined: masks not stored or compared; equal word address alone is a violation
//  (conservative; extra replays, never a missed one). IN_size is ignored.
// STRUCTURE
//  Shared package: BranchProv_t {taken, dstPC[31:0], sqN, storeSqN, loadSqN, flush}, SqN_t,
//  LQEntry_t, function is_older(a,b), function size_to_mask(size, addr[1:0]).
//  Sub-module lq_violation_select: per-port violation flags + sqN -> oldest port index, valid.
// TESTING
//  1. Reset mid-run with 5 valid entries -> outputs at reset values the same cycle; maxLoadSqN=15.
//  2. Load sqN=10 addr 0x100 word; next cycle store sqN=8 addr 0x102 half -> next cycle
//     OUT_branch.taken=1, dstPC=store pc, sqN=8, flush=0.
//  3. Same as 2 but store sqN=12 -> no branch; and with LQ_BYTE_MASK_EN, store byte 0x104 vs
//     load byte 0x105 -> no branch; without the macro -> branch.
//  4. Stores sqN=20 (port0) and sqN=17 (port1) both violate -> OUT_branch.sqN=17.
//  5. Entries sqN 3,4,5 at head, commitSqN=6, COMMIT_W=2 -> 2 retire, then 1; maxLoadSqN +2, +1.
//  6. Head near wrap (head=62, SQN_W=6): IN_branch sqN=1 flush, loadSqN=60 -> entries sqN>1
//     cleared, head=60; same-cycle store sqN=2 killed -> no OUT_branch.

Source files
------------

// File: rtl/load_order_queue_pkg.sv
// ============================================================================
//  Module   : load_order_queue_pkg
//  Brief    : Shared types and helpers for the load-ordering queue.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package load_order_queue_pkg;

    localparam int SQN_W = 6;

    typedef logic [SQN_W-1:0] SqN_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] dstPC;
        SqN_t        sqN;
        SqN_t        storeSqN;
        SqN_t        loadSqN;
        logic        flush;
    } BranchProv_t;

    typedef struct packed {
        logic        valid;
        SqN_t        sqN;
        logic [29:0] addr;
`ifdef LQ_BYTE_MASK_EN
        logic [3:0]  mask;
`endif
    } LQEntry_t;

    // a is older than b when the wrapped difference is negative
    function automatic logic is_older(SqN_t a, SqN_t b);
        SqN_t d;
        d = a - b;
        return d[SQN_W-1];
    endfunction

    function automatic logic [3:0] size_to_mask(logic [1:0] size, logic [1:0] off);
        case (size)
            2'd0:    size_to_mask = 4'b0001 << off;
            2'd1:    size_to_mask = off[1] ? 4'b1100 : 4'b0011;
            default: size_to_mask = 4'b1111;
        endcase
    endfunction

    // A recorded/in-flight load ld conflicts with store st if it is younger and touches its bytes
    function automatic logic conflicts(LQEntry_t ld, LQEntry_t st);
        logic c;
        c = ld.valid && (ld.addr == st.addr) && is_older(st.sqN, ld.sqN);
`ifdef LQ_BYTE_MASK_EN
        c = c && (|(ld.mask & st.mask));
`endif
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_order_queue_if.sv
// ============================================================================
//  Module   : load_order_queue_if
//  Brief    : AGU op, branch and status bundle between the LSU and the load queue.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface load_order_queue_if import load_order_queue_pkg::*; #(
    parameter int NUM_PORTS = 2
) ();

    SqN_t                       IN_commitSqN;
    logic [NUM_PORTS-1:0]       IN_valid;
    logic [NUM_PORTS-1:0]       IN_isLoad;
    logic [NUM_PORTS-1:0][31:0] IN_pc;
    logic [NUM_PORTS-1:0][31:0] IN_addr;
    logic [NUM_PORTS-1:0][1:0]  IN_size;
    SqN_t [NUM_PORTS-1:0]       IN_sqN;
    SqN_t [NUM_PORTS-1:0]       IN_loadSqN;
    SqN_t [NUM_PORTS-1:0]       IN_storeSqN;
    BranchProv_t                IN_branch;
    BranchProv_t                OUT_branch;
    SqN_t                       OUT_maxLoadSqN;

    modport master (
        output IN_commitSqN, IN_valid, IN_isLoad, IN_pc, IN_addr, IN_size,
               IN_sqN, IN_loadSqN, IN_storeSqN, IN_branch,
        input  OUT_branch, OUT_maxLoadSqN
    );

    modport slave (
        input  IN_commitSqN, IN_valid, IN_isLoad, IN_pc, IN_addr, IN_size,
               IN_sqN, IN_loadSqN, IN_storeSqN, IN_branch,
        output OUT_branch, OUT_maxLoadSqN
    );

endinterface

`default_nettype wire

// File: rtl/load_order_queue_violation_select.sv
// ============================================================================
//  Module   : lq_violation_select
//  Brief    : Picks the violating store port with the oldest sqN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lq_violation_select import load_order_queue_pkg::*; #(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  wire logic [NUM_PORTS-1:0] i_flag,
    input  wire SqN_t [NUM_PORTS-1:0] i_sqn,
    output logic      [PORT_W-1:0]    o_idx,
    output logic                      o_valid
);

    always_comb begin
        logic found;
        SqN_t best;
        found = 1'b0;
        best  = '0;
        o_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (i_flag[i] && (!found || is_older(i_sqn[i], best))) begin
                found = 1'b1;
                best  = i_sqn[i];
                o_idx = PORT_W'(i);
            end
        end
        o_valid = found;
    end

endmodule

`default_nettype wire

// File: rtl/load_order_queue.sv
// ============================================================================
//  Module   : load_order_queue
//  Brief    : Circular load-ordering queue; detects store/load ordering
//             violations and retires committed loads. Optional byte-mask
//             overlap compare enabled by LQ_BYTE_MASK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module load_order_queue import load_order_queue_pkg::*; #(
    parameter int NUM_PORTS   = 2,
    parameter int NUM_ENTRIES = 16,
    parameter int COMMIT_W    = 2
) (
    input wire logic          clk,
    input wire logic          rst,
    load_order_queue_if.slave lq
);

    localparam int IDX_W  = $clog2(NUM_ENTRIES);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    LQEntry_t    ent_q [NUM_ENTRIES];
    LQEntry_t    ent_d [NUM_ENTRIES];
    SqN_t        head_q, head_d;
    SqN_t        max_load_sqn_q, max_load_sqn_d;
    BranchProv_t branch_q, branch_d;

    LQEntry_t             w_op [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_viol;
    logic [PORT_W-1:0]    w_sel_idx;
    logic                 w_sel_valid;

    wire w_unused_bits = ^{lq.IN_branch.dstPC, lq.IN_branch.storeSqN
`ifndef LQ_BYTE_MASK_EN
                           , lq.IN_size, lq.IN_addr
`endif
                          };

    // Port ops in entry form; valid means issued and not killed by the incoming branch
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_op[p]       = '0;
            w_op[p].valid = lq.IN_valid[p] &&
                            !(lq.IN_branch.taken && is_older(lq.IN_branch.sqN, lq.IN_sqN[p]));
            w_op[p].sqN   = lq.IN_sqN[p];
            w_op[p].addr  = lq.IN_addr[p][31:2];
`ifdef LQ_BYTE_MASK_EN
            w_op[p].mask  = size_to_mask(lq.IN_size[p], lq.IN_addr[p][1:0]);
`endif
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_viol[p] = 1'b0;
            if (w_op[p].valid && !lq.IN_isLoad[p]) begin
                for (int e = 0; e < NUM_ENTRIES; e++) begin
                    if (conflicts(ent_q[e], w_op[p])) w_viol[p] = 1'b1;
                end
                for (int q = 0; q < NUM_PORTS; q++) begin
                    if (q != p && lq.IN_isLoad[q] && conflicts(w_op[q], w_op[p]))
                        w_viol[p] = 1'b1;
                end
            end
        end
    end

    lq_violation_select #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_sel (
        .i_flag  (w_viol),
        .i_sqn   (lq.IN_sqN),
        .o_idx   (w_sel_idx),
        .o_valid (w_sel_valid)
    );

    always_comb begin
        branch_d = '0;
        if (w_sel_valid) begin
            branch_d.taken    = 1'b1;
            branch_d.dstPC    = lq.IN_pc[w_sel_idx];
            branch_d.sqN      = lq.IN_sqN[w_sel_idx];
            branch_d.loadSqN  = lq.IN_loadSqN[w_sel_idx];
            branch_d.storeSqN = lq.IN_storeSqN[w_sel_idx];
            branch_d.flush    = 1'b0;
        end
    end

    // Mispredict or retire first, then inserts so a slot freed this cycle can be reused
    always_comb begin
        logic       go;
        int         n;
        logic [IDX_W-1:0] idx;
        ent_d  = ent_q;
        head_d = head_q;
        go     = 1'b1;
        n      = 0;
        idx    = '0;
        if (lq.IN_branch.taken) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (is_older(lq.IN_branch.sqN, ent_q[e].sqN)) ent_d[e].valid = 1'b0;
            end
            if (lq.IN_branch.flush) head_d = lq.IN_branch.loadSqN;
        end else begin
            for (int i = 0; i < COMMIT_W; i++) begin
                idx = head_q[IDX_W-1:0] + IDX_W'(i);
                if (go && ent_q[idx].valid && is_older(ent_q[idx].sqN, lq.IN_commitSqN)) begin
                    ent_d[idx].valid = 1'b0;
                    n = n + 1;
                end else begin
                    go = 1'b0;
                end
            end
            head_d = head_q + SQN_W'(n);
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_op[p].valid && lq.IN_isLoad[p]) begin
                ent_d[lq.IN_loadSqN[p][IDX_W-1:0]] = w_op[p];
            end
        end
        max_load_sqn_d = head_d + SQN_W'(NUM_ENTRIES - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_ENTRIES; e++) ent_q[e] <= '0;
            head_q         <= '0;
            branch_q       <= '0;
            max_load_sqn_q <= SQN_W'(NUM_ENTRIES - 1);
        end else begin
            for (int e = 0; e < NUM_ENTRIES; e++) ent_q[e] <= ent_d[e];
            head_q         <= head_d;
            branch_q       <= branch_d;
            max_load_sqn_q <= max_load_sqn_d;
        end
    end

    assign lq.OUT_branch     = branch_q;
    assign lq.OUT_maxLoadSqN = max_load_sqn_q;

endmodule

`default_nettype wire

// File: tb/tb_load_order_queue.sv
// ============================================================================
//  Module   : tb_load_order_queue
//  Brief    : Directed self-checking bench for load_order_queue.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_order_queue;
    import load_order_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    load_order_queue_if #(.NUM_PORTS(2)) lq_if ();

    load_order_queue #(
        .NUM_PORTS   (2),
        .NUM_ENTRIES (16),
        .COMMIT_W    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lq  (lq_if.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ops();
        lq_if.IN_valid    = '0;
        lq_if.IN_isLoad   = '0;
        lq_if.IN_pc       = '0;
        lq_if.IN_addr     = '0;
        lq_if.IN_size     = '0;
        lq_if.IN_sqN      = '0;
        lq_if.IN_loadSqN  = '0;
        lq_if.IN_storeSqN = '0;
        lq_if.IN_branch   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_ops();
    endtask

    task automatic put_load(input int p, input SqN_t sqn, input SqN_t lsqn,
                            input logic [31:0] addr, input logic [1:0] size);
        SqN_t diff;
        // upstream must stay inside the allocatable window
        diff = lsqn - lq_if.OUT_maxLoadSqN;
        check("lsqn_window", {63'd0, diff[SQN_W-1] || (diff == '0)}, 64'd1);
        lq_if.IN_valid[p]   = 1'b1;
        lq_if.IN_isLoad[p]  = 1'b1;
        lq_if.IN_sqN[p]     = sqn;
        lq_if.IN_loadSqN[p] = lsqn;
        lq_if.IN_addr[p]    = addr;
        lq_if.IN_size[p]    = size;
        lq_if.IN_pc[p]      = 32'h0000_8000 + {26'd0, sqn};
    endtask

    task automatic put_store(input int p, input SqN_t sqn, input SqN_t lsqn, input SqN_t ssqn,
                             input logic [31:0] addr, input logic [1:0] size, input logic [31:0] pc);
        lq_if.IN_valid[p]    = 1'b1;
        lq_if.IN_isLoad[p]   = 1'b0;
        lq_if.IN_sqN[p]      = sqn;
        lq_if.IN_loadSqN[p]  = lsqn;
        lq_if.IN_storeSqN[p] = ssqn;
        lq_if.IN_addr[p]     = addr;
        lq_if.IN_size[p]     = size;
        lq_if.IN_pc[p]       = pc;
    endtask

    task automatic put_branch(input SqN_t sqn, input SqN_t lsqn, input logic flush);
        lq_if.IN_branch.taken   = 1'b1;
        lq_if.IN_branch.sqN     = sqn;
        lq_if.IN_branch.loadSqN = lsqn;
        lq_if.IN_branch.flush   = flush;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_ops();
        lq_if.IN_commitSqN = '0;

        // 1. reset values, then asynchronous reset mid-run with 5 valid entries
        do_reset();
        check("rst_taken", lq_if.OUT_branch.taken, 1'b0);
        check("rst_max", lq_if.OUT_maxLoadSqN, 6'd15);
        put_load(0, 6'd1, 6'd0, 32'h200, 2'd2);
        put_load(1, 6'd2, 6'd1, 32'h204, 2'd2);
        step();
        put_load(0, 6'd3, 6'd2, 32'h208, 2'd2);
        put_load(1, 6'd4, 6'd3, 32'h20C, 2'd2);
        step();
        put_load(0, 6'd5, 6'd4, 32'h210, 2'd2);
        step();
        put_store(0, 6'd0, 6'd0, 6'd0, 32'h200, 2'd2, 32'h1000);
        step();
        check("t1_pre_taken", lq_if.OUT_branch.taken, 1'b1);
        check("t1_pre_sqn", lq_if.OUT_branch.sqN, 6'd0);
        rst = 1'b1;
        #1;
        check("t1_async_taken", lq_if.OUT_branch.taken, 1'b0);
        check("t1_async_max", lq_if.OUT_maxLoadSqN, 6'd15);
        step();
        rst = 1'b0;
        put_store(0, 6'd0, 6'd0, 6'd0, 32'h200, 2'd2, 32'h1000);
        step();
        check("t1_cleared", lq_if.OUT_branch.taken, 1'b0);

        // 2. younger load already executed, older store hits it
        put_load(0, 6'd10, 6'd5, 32'h100, 2'd2);
        step();
        put_store(1, 6'd8, 6'd5, 6'd3, 32'h102, 2'd1, 32'h4000_0010);
        step();
        check("t2_taken", lq_if.OUT_branch.taken, 1'b1);
        check("t2_pc", lq_if.OUT_branch.dstPC, 32'h4000_0010);
        check("t2_sqn", lq_if.OUT_branch.sqN, 6'd8);
        check("t2_lsqn", lq_if.OUT_branch.loadSqN, 6'd5);
        check("t2_ssqn", lq_if.OUT_branch.storeSqN, 6'd3);
        check("t2_flush", lq_if.OUT_branch.flush, 1'b0);
        step();
        check("t2_pulse", lq_if.OUT_branch.taken, 1'b0);

        // 3. store younger than the load; then disjoint bytes in one word
        put_store(0, 6'd12, 6'd6, 6'd4, 32'h102, 2'd1, 32'h4000_0020);
        step();
        check("t3_younger", lq_if.OUT_branch.taken, 1'b0);
        put_load(0, 6'd14, 6'd6, 32'h105, 2'd0);
        step();
        put_store(1, 6'd13, 6'd6, 6'd5, 32'h104, 2'd0, 32'h4000_0030);
        step();
`ifdef LQ_BYTE_MASK_EN
        check("t3_bytes", lq_if.OUT_branch.taken, 1'b0);
`else
        check("t3_bytes", lq_if.OUT_branch.taken, 1'b1);
`endif
        step();

        // 4. two violating stores: oldest wins; then same-cycle load on the other port
        put_load(0, 6'd22, 6'd7, 32'h300, 2'd2);
        put_load(1, 6'd21, 6'd8, 32'h304, 2'd2);
        step();
        put_store(0, 6'd20, 6'd9, 6'd6, 32'h300, 2'd2, 32'h0000_00A0);
        put_store(1, 6'd17, 6'd9, 6'd7, 32'h304, 2'd2, 32'h0000_00B0);
        step();
        check("t4_taken", lq_if.OUT_branch.taken, 1'b1);
        check("t4_sqn", lq_if.OUT_branch.sqN, 6'd17);
        check("t4_pc", lq_if.OUT_branch.dstPC, 32'h0000_00B0);
        put_load(0, 6'd30, 6'd9, 32'h400, 2'd2);
        put_store(1, 6'd29, 6'd10, 6'd8, 32'h400, 2'd2, 32'h0000_00B4);
        step();
        check("t4_same_taken", lq_if.OUT_branch.taken, 1'b1);
        check("t4_same_sqn", lq_if.OUT_branch.sqN, 6'd29);

        // 5. retire at most two per cycle from the head
        do_reset();
        put_load(0, 6'd3, 6'd0, 32'h600, 2'd2);
        put_load(1, 6'd4, 6'd1, 32'h604, 2'd2);
        step();
        put_load(0, 6'd5, 6'd2, 32'h608, 2'd2);
        step();
        put_store(0, 6'd2, 6'd3, 6'd0, 32'h600, 2'd2, 32'h0000_0C00);
        step();
        check("t5_present", lq_if.OUT_branch.taken, 1'b1);
        check("t5_max0", lq_if.OUT_maxLoadSqN, 6'd15);
        lq_if.IN_commitSqN = 6'd6;
        step();
        check("t5_max1", lq_if.OUT_maxLoadSqN, 6'd17);
        step();
        check("t5_max2", lq_if.OUT_maxLoadSqN, 6'd18);
        step();
        check("t5_max3", lq_if.OUT_maxLoadSqN, 6'd18);
        put_store(0, 6'd2, 6'd3, 6'd0, 32'h600, 2'd2, 32'h0000_0C00);
        step();
        check("t5_retired", lq_if.OUT_branch.taken, 1'b0);

        // 6. head near wrap; flush with a killed same-cycle store
        do_reset();
        lq_if.IN_commitSqN = 6'd63;
        put_branch(6'd50, 6'd62, 1'b1);
        step();
        check("t6_head62_max", lq_if.OUT_maxLoadSqN, 6'd13);
        put_load(0, 6'd63, 6'd62, 32'h500, 2'd2);
        put_load(1, 6'd0, 6'd63, 32'h504, 2'd2);
        step();
        put_load(0, 6'd2, 6'd0, 32'h508, 2'd2);
        put_load(1, 6'd3, 6'd1, 32'h50C, 2'd2);
        step();
        put_branch(6'd1, 6'd60, 1'b1);
        put_store(0, 6'd2, 6'd2, 6'd0, 32'h50C, 2'd2, 32'h0000_00C0);
        step();
        check("t6_killed", lq_if.OUT_branch.taken, 1'b0);
        check("t6_head60_max", lq_if.OUT_maxLoadSqN, 6'd11);
        put_store(0, 6'd1, 6'd2, 6'd0, 32'h508, 2'd2, 32'h0000_00D0);
        put_store(1, 6'd1, 6'd2, 6'd0, 32'h50C, 2'd2, 32'h0000_00D4);
        step();
        check("t6_young_cleared", lq_if.OUT_branch.taken, 1'b0);
        put_store(0, 6'd62, 6'd2, 6'd0, 32'h504, 2'd2, 32'h0000_00E0);
        step();
        check("t6_old_kept", lq_if.OUT_branch.taken, 1'b1);
        check("t6_old_sqn", lq_if.OUT_branch.sqN, 6'd62);
        check("t6_old_pc", lq_if.OUT_branch.dstPC, 32'h0000_00E0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
